// File: rtl/bcd_pkg.sv
// bcd_pkg: shared widths, iteration count and FSM encoding for bcd2bin_seq.
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam int BIN_W = 10;
  localparam int ITERS = 10;
  localparam int CNT_W = 4;
  localparam int WORK_W = 3 * DIGIT_W + BIN_W;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/bcd2bin_seq_if.sv
// bcd2bin_seq_if: operand/result handshake bundle for bcd2bin_seq.
interface bcd2bin_seq_if;
  import bcd_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [DIGIT_W-1:0] hundreds;
  logic [DIGIT_W-1:0] tens;
  logic [DIGIT_W-1:0] ones;
  logic out_valid;
  logic out_ready;
  logic [BIN_W-1:0] bin;
  logic err;
  modport master (
    output in_valid, hundreds, tens, ones, out_ready,
    input in_ready, out_valid, bin, err
  );
  modport slave (
    input in_valid, hundreds, tens, ones, out_ready,
    output in_ready, out_valid, bin, err
  );
endinterface

// File: rtl/bcd2bin_seq_sub3.sv
// sub3: per-digit correction of reverse double-dabble, minus 3 when digit >= 8.
module sub3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  output logic [DIGIT_W-1:0] y
);
  assign y = a >= 4'd8 ? a - 4'd3 : a;
endmodule

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential 3-digit BCD to 10-bit binary converter (reverse double-dabble).
// Define BCD2BIN_CHECK_EN to flag digits above 9 with err and a one-cycle fast path.
module bcd2bin_seq
  import bcd_pkg::*;
(
  input logic clk,
  input logic rst_n,
  bcd2bin_seq_if.slave bus
);
  state_t state, nxt;
  logic [WORK_W-1:0] w, sh, nw;
  logic [CNT_W-1:0] cnt;
  logic acc, bad;
  assign acc = state == IDLE && bus.in_valid;
  assign sh = w >> 1;
  sub3 u_h (.a(sh[WORK_W-1 -: DIGIT_W]), .y(nw[WORK_W-1 -: DIGIT_W]));
  sub3 u_t (.a(sh[BIN_W+2*DIGIT_W-1 -: DIGIT_W]), .y(nw[BIN_W+2*DIGIT_W-1 -: DIGIT_W]));
  sub3 u_o (.a(sh[BIN_W+DIGIT_W-1 -: DIGIT_W]), .y(nw[BIN_W+DIGIT_W-1 -: DIGIT_W]));
  assign nw[BIN_W-1:0] = sh[BIN_W-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = acc ? (bad ? DONE : SHIFT) : IDLE;
      SHIFT: nxt = cnt == CNT_W'(ITERS - 1) ? DONE : SHIFT;
      DONE: nxt = bus.out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w <= '0;
      cnt <= '0;
    end else if (acc) begin
      w <= bad ? '0 : {bus.hundreds, bus.tens, bus.ones, BIN_W'(0)};
      cnt <= '0;
    end else if (state == SHIFT) begin
      w <= nw;
      cnt <= cnt + 1'b1;
    end
`ifdef BCD2BIN_CHECK_EN
  logic err_q;
  assign bad = (bus.hundreds > 4'd9) | (bus.tens > 4'd9) | (bus.ones > 4'd9);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else if (acc) err_q <= bad;
  assign bus.err = err_q;
`else
  assign bad = 1'b0;
  assign bus.err = 1'b0;
`endif
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.bin = w[BIN_W-1:0];
endmodule

// File: doc/bcd2bin_seq.md
BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 CLK  input  1  single clock; all state updates on rising edge.
REQ-002 RST_N  input  1  reset, asynchronous, active-low.
REQ-003 IN_VALID  input  1  BCD operand presented.
REQ-004 IN_READY  output  1  block can accept an operand.
REQ-005 HUNDREDS  input  4  BCD hundreds digit.
REQ-006 TENS  input  4  BCD tens digit.
REQ-007 ONES  input  4  BCD ones digit.
REQ-008 OUT_VALID  output  1  result available.
REQ-009 OUT_READY  input  1  consumer takes result.
REQ-010 BIN  output  10  binary value, HUNDREDS*100 + TENS*10 + ONES (0..999).
REQ-011 ERR  output  1  operand contained a digit above 9; qualified by OUT_VALID.

Function
REQ-012 The block SHALL use the reverse double-dabble method: a 22-bit working register {BCD[11:0], BIN[9:0]}, shifted right one bit per cycle, with each 4-bit BCD digit reduced by 3 after the shift when the digit is 8 or more.
REQ-013 The block SHALL implement states IDLE, SHIFT and DONE.
REQ-014 IN_READY SHALL be high only in IDLE; a transfer occurs on a rising edge with IN_VALID and IN_READY both high.
REQ-015 On transfer, the block SHALL load {HUNDREDS,TENS,ONES} into BCD, clear BIN, clear the 4-bit iteration counter, and enter SHIFT.
REQ-016 SHIFT SHALL perform exactly 10 iterations, one per cycle, then enter DONE.
REQ-017 OUT_VALID SHALL be high exactly in DONE: first high 10 cycles after the accepting edge.
REQ-018 BIN and ERR SHALL be registered and stable while OUT_VALID is high.
REQ-019 DONE SHALL hold until OUT_READY is high on an edge, then return to IDLE; OUT_VALID and OUT_READY high on the same edge SHALL complete the output transfer.
REQ-020 IN_VALID SHALL be ignored outside IDLE, and input digits SHALL be sampled only on the accepting edge.
REQ-021 Minimum throughput SHALL be one operand per 12 cycles (accept, 10 shifts, output handshake).

Reset
REQ-022 RST_N low SHALL force IDLE immediately, regardless of state, including mid-SHIFT or in DONE.
REQ-023 During and after reset: OUT_VALID=0, BIN=0, ERR=0, IN_READY=1, counter=0.
REQ-024 An operand in flight when reset asserts SHALL be discarded without producing output.

Configuration
REQ-025 With macro BCD2BIN_CHECK_EN defined, an accepted operand with any digit above 9 SHALL skip SHIFT: DONE on the next edge, BIN=0, ERR=1.
REQ-026 Without BCD2BIN_CHECK_EN, ERR SHALL be tied 0, every operand SHALL take the 10-cycle path, and BIN for invalid digits is unspecified.

Structure
REQ-027 Shared package bcd_pkg SHALL hold the digit width (4), the binary width (10), the iteration count (10) and the state encodings.
REQ-028 Sub-module sub3 SHALL implement the per-digit correction: 4-bit in, 4-bit out, minus 3 when the input is 8 or more, otherwise pass-through.
REQ-029 bcd2bin_seq SHALL instantiate sub3 three times.

Verification
REQ-030 Digits 2,5,5 with OUT_READY=1 -> OUT_VALID high 10 cycles after acceptance, BIN=255 (0x0FF), ERR=0.
REQ-031 Sweep 0,0,0 through 9,9,9 -> BIN equals the decimal value for all 1000 operands; 9,9,9 -> 999 (0x3E7).
REQ-032 Operand 1,2,3 with OUT_READY=0 for 5 cycles in DONE -> BIN=123 held, IN_READY=0, a new IN_VALID is ignored; OUT_READY=1 -> IDLE on the next edge.
REQ-033 Back-to-back operands 0,0,1 and 4,0,0 with IN_VALID held high and OUT_READY=1 -> results 1 then 400, second accepted on the edge after the first completes.
REQ-034 RST_N pulsed low 4 cycles into the conversion of 7,7,7 -> OUT_VALID never rises for that operand; the next operand 0,4,2 -> BIN=42.
REQ-035 With BCD2BIN_CHECK_EN: operand 0,0xA,3 -> OUT_VALID one cycle after acceptance, BIN=0, ERR=1; without the macro, ERR stays 0.
